// File: rtl/sat_pkg.sv
// Shared state encoding and default sizing for the SAT engine loader.
package sat_pkg;

  localparam int NUM_CLAUSES_DEF      = 8;
  localparam int NUM_VARS_DEF         = 8;
  localparam int NUM_LVLS_DEF         = 8;
  localparam int WIDTH_LVL_DEF        = 16;
  localparam int WIDTH_VAR_STATES_DEF = 19;
  localparam int WIDTH_LVL_STATES_DEF = 16;
  localparam int WAIT_MAX_DEF         = 4096;
  localparam int READBACK_DEF         = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_CL,
    WR_VS,
    WR_LS,
    START,
    WAIT,
    RD_REQ,
    RD_OUT,
    FIN
  } state_e;

  // A single-row array still needs a one-bit row index.
  function automatic int row_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Binary-to-one-hot row decoder with enable; all-zero output when disabled.
module onehot_dec #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         en_i,
  input  logic [W-1:0] bin_i,
  output logic [N-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < N; i++) begin
      if (en_i && (bin_i == W'(i))) onehot_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/sat_engine_loader.sv
// Loads one bin of clauses and var/level state into the SAT core, starts it,
// waits for a verdict (with timeout) and optionally streams the clause array back.
//
// state  | meaning
// IDLE   | waiting for go_i; job inputs captured on go
// WR_CL  | accepting clause beats, one array row per beat
// WR_VS  | one-cycle write of all var states
// WR_LS  | one-cycle write of all level states
// START  | one-cycle start / base-level enable to the core
// WAIT   | waiting for done_core_i, bounded by WAIT_MAX
// RD_REQ | read strobe for the current row
// RD_OUT | readback beat held until rb_ready_i
// FIN    | one-cycle done pulse
module sat_engine_loader
  import sat_pkg::*;
#(
  parameter int NUM_CLAUSES      = NUM_CLAUSES_DEF,
  parameter int NUM_VARS         = NUM_VARS_DEF,
  parameter int NUM_LVLS         = NUM_LVLS_DEF,
  parameter int WIDTH_LVL        = WIDTH_LVL_DEF,
  parameter int WIDTH_VAR_STATES = WIDTH_VAR_STATES_DEF,
  parameter int WIDTH_LVL_STATES = WIDTH_LVL_STATES_DEF,
  parameter int WAIT_MAX         = WAIT_MAX_DEF,
  parameter int READBACK         = READBACK_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 go_i,
  input  logic [WIDTH_LVL-1:0]                 cur_bin_num_i,
  input  logic [WIDTH_LVL-1:0]                 load_lvl_i,
  input  logic [WIDTH_LVL-1:0]                 base_lvl_i,
  input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] var_states_i,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i,
  input  logic                                 cl_valid_i,
  output logic                                 cl_ready_o,
  input  logic [NUM_VARS*2-1:0]                cl_data_i,
  output logic [NUM_CLAUSES-1:0]               wr_carray_o,
  output logic [NUM_CLAUSES-1:0]               rd_carray_o,
  output logic [NUM_VARS*2-1:0]                clause_o,
  input  logic [NUM_VARS*2-1:0]                clause_i,
  output logic [NUM_VARS-1:0]                  wr_var_states_o,
  output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] var_states_o,
  output logic [NUM_LVLS-1:0]                  wr_lvl_states_o,
  output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_o,
  output logic                                 start_core_o,
  output logic [WIDTH_LVL-1:0]                 cur_bin_num_o,
  output logic [WIDTH_LVL-1:0]                 load_lvl_o,
  output logic [WIDTH_LVL-1:0]                 base_lvl_o,
  output logic                                 base_lvl_en_o,
  input  logic                                 done_core_i,
  input  logic                                 sat_i,
  input  logic                                 unsat_i,
  output logic                                 rb_valid_o,
  input  logic                                 rb_ready_i,
  output logic [NUM_VARS*2-1:0]                rb_data_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 sat_o,
  output logic                                 unsat_o,
  output logic                                 timeout_o
);

  localparam int ROW_W = row_width(NUM_CLAUSES);
  localparam int CNT_W = $clog2(WAIT_MAX) + 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_CLAUSES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  state_e                              state_q, state_d;
  logic [ROW_W-1:0]                    row_q, row_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [CNT_W-1:0]                    cnt_inc;
  logic [WIDTH_LVL-1:0]                cur_bin_q, cur_bin_d;
  logic [WIDTH_LVL-1:0]                load_lvl_q, load_lvl_d;
  logic [WIDTH_LVL-1:0]                base_lvl_q, base_lvl_d;
  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] var_states_q, var_states_d;
  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_q, lvl_states_d;
  logic                                sat_q, sat_d;
  logic                                unsat_q, unsat_d;
  logic                                timeout_q, timeout_d;
  logic                                rb_valid_q, rb_valid_d;
  logic [NUM_VARS*2-1:0]               rb_data_q, rb_data_d;

  logic                                wr_beat;
  logic                                dec_en;
  logic [NUM_CLAUSES-1:0]              row_oh;

  assign cnt_inc = cnt_q + 1'b1;
  assign wr_beat = (state_q == WR_CL) && cl_valid_i;
  assign dec_en  = wr_beat || (state_q == RD_REQ);

  onehot_dec #(
    .N (NUM_CLAUSES),
    .W (ROW_W)
  ) u_row_dec (
    .en_i     (dec_en),
    .bin_i    (row_q),
    .onehot_o (row_oh)
  );

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    cnt_d        = cnt_q;
    cur_bin_d    = cur_bin_q;
    load_lvl_d   = load_lvl_q;
    base_lvl_d   = base_lvl_q;
    var_states_d = var_states_q;
    lvl_states_d = lvl_states_q;
    sat_d        = sat_q;
    unsat_d      = unsat_q;
    timeout_d    = timeout_q;
    rb_valid_d   = rb_valid_q;
    rb_data_d    = rb_data_q;

    case (state_q)
      IDLE: begin
        if (go_i) begin
          cur_bin_d    = cur_bin_num_i;
          load_lvl_d   = load_lvl_i;
          base_lvl_d   = base_lvl_i;
          var_states_d = var_states_i;
          lvl_states_d = lvl_states_i;
          sat_d        = 1'b0;
          unsat_d      = 1'b0;
          timeout_d    = 1'b0;
          row_d        = '0;
          state_d      = WR_CL;
        end
      end
      WR_CL: begin
        if (cl_valid_i) begin
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = WR_VS;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      WR_VS: state_d = WR_LS;
      WR_LS: state_d = START;
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (done_core_i) begin
          sat_d   = sat_i;
          unsat_d = unsat_i;
          row_d   = '0;
          state_d = (READBACK != 0) ? RD_REQ : FIN;
        end else begin
          // Timeout fires as the count reaches WAIT_MAX-1, so done_o lands
          // exactly WAIT_MAX cycles after the start pulse.
          cnt_d = cnt_inc;
          if (cnt_inc >= CNT_LAST) begin
            timeout_d = 1'b1;
            state_d   = FIN;
          end
        end
      end
      RD_REQ: begin
        rb_data_d  = clause_i;
        rb_valid_d = 1'b1;
        state_d    = RD_OUT;
      end
      RD_OUT: begin
        if (rb_ready_i) begin
          rb_valid_d = 1'b0;
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = FIN;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      cnt_q        <= '0;
      cur_bin_q    <= '0;
      load_lvl_q   <= '0;
      base_lvl_q   <= '0;
      var_states_q <= '0;
      lvl_states_q <= '0;
      sat_q        <= 1'b0;
      unsat_q      <= 1'b0;
      timeout_q    <= 1'b0;
      rb_valid_q   <= 1'b0;
      rb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      cur_bin_q    <= cur_bin_d;
      load_lvl_q   <= load_lvl_d;
      base_lvl_q   <= base_lvl_d;
      var_states_q <= var_states_d;
      lvl_states_q <= lvl_states_d;
      sat_q        <= sat_d;
      unsat_q      <= unsat_d;
      timeout_q    <= timeout_d;
      rb_valid_q   <= rb_valid_d;
      rb_data_q    <= rb_data_d;
    end
  end

  // Clause writes follow the feed handshake in the same cycle.
  assign wr_carray_o     = (state_q == WR_CL) ? row_oh : '0;
  assign rd_carray_o     = (state_q == RD_REQ) ? row_oh : '0;
  assign clause_o        = wr_beat ? cl_data_i : '0;
  assign cl_ready_o      = (state_q == WR_CL);
  assign wr_var_states_o = {NUM_VARS{state_q == WR_VS}};
  assign wr_lvl_states_o = {NUM_LVLS{state_q == WR_LS}};
  assign var_states_o    = var_states_q;
  assign lvl_states_o    = lvl_states_q;
  assign start_core_o    = (state_q == START);
  assign base_lvl_en_o   = (state_q == START);
  assign cur_bin_num_o   = cur_bin_q;
  assign load_lvl_o      = load_lvl_q;
  assign base_lvl_o      = base_lvl_q;
  assign rb_valid_o      = rb_valid_q;
  assign rb_data_o       = rb_data_q;
  assign busy_o          = (state_q != IDLE);
  assign done_o          = (state_q == FIN);
  assign sat_o           = sat_q;
  assign unsat_o         = unsat_q;
  assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_sat_engine_loader.sv
// Directed bench: default loader (readback, long timeout) plus a second
// instance with WAIT_MAX=16 and READBACK=0.
module tb_sat_engine_loader;

  localparam int NC  = 8;
  localparam int NV  = 8;
  localparam int NL  = 8;
  localparam int WL  = 16;
  localparam int WVS = 19;
  localparam int WLS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [WL-1:0]     cur_bin = '0, load_lvl = '0, base_lvl = '0;
  logic [WVS*NV-1:0] var_states = '0;
  logic [WLS*NL-1:0] lvl_states = '0;
  logic              cl_valid = 1'b0;
  logic [NV*2-1:0]   cl_data = '0;
  logic              sat_in = 1'b0, unsat_in = 1'b0, rb_ready = 1'b0;
  logic              go_a = 1'b0, go_b = 1'b0, done_core_a = 1'b0, done_core_b = 1'b0;

  logic              cl_ready_a, start_a, base_en_a, rb_valid_a, busy_a, done_a;
  logic              sat_a, unsat_a, timeout_a;
  logic [NC-1:0]     wr_carray_a, rd_carray_a;
  logic [NV*2-1:0]   clause_o_a, clause_i_a, rb_data_a;
  logic [NV-1:0]     wr_vs_a;
  logic [NL-1:0]     wr_ls_a;
  logic [WVS*NV-1:0] vs_o_a;
  logic [WLS*NL-1:0] ls_o_a;
  logic [WL-1:0]     cur_bin_o_a, load_lvl_o_a, base_lvl_o_a;

  logic              cl_ready_b, start_b, base_en_b, rb_valid_b, busy_b, done_b;
  logic              sat_b, unsat_b, timeout_b;
  logic [NC-1:0]     wr_carray_b, rd_carray_b;
  logic [NV*2-1:0]   clause_o_b, rb_data_b;
  logic [NV*2-1:0]   clause_i_b = '0;
  logic [NV-1:0]     wr_vs_b;
  logic [NL-1:0]     wr_ls_b;
  logic [WVS*NV-1:0] vs_o_b;
  logic [WLS*NL-1:0] ls_o_b;
  logic [WL-1:0]     cur_bin_o_b, load_lvl_o_b, base_lvl_o_b;

  sat_engine_loader u_dut_a (
    .clk(clk), .rst(rst), .go_i(go_a),
    .cur_bin_num_i(cur_bin), .load_lvl_i(load_lvl), .base_lvl_i(base_lvl),
    .var_states_i(var_states), .lvl_states_i(lvl_states),
    .cl_valid_i(cl_valid), .cl_ready_o(cl_ready_a), .cl_data_i(cl_data),
    .wr_carray_o(wr_carray_a), .rd_carray_o(rd_carray_a),
    .clause_o(clause_o_a), .clause_i(clause_i_a),
    .wr_var_states_o(wr_vs_a), .var_states_o(vs_o_a),
    .wr_lvl_states_o(wr_ls_a), .lvl_states_o(ls_o_a),
    .start_core_o(start_a), .cur_bin_num_o(cur_bin_o_a),
    .load_lvl_o(load_lvl_o_a), .base_lvl_o(base_lvl_o_a), .base_lvl_en_o(base_en_a),
    .done_core_i(done_core_a), .sat_i(sat_in), .unsat_i(unsat_in),
    .rb_valid_o(rb_valid_a), .rb_ready_i(rb_ready), .rb_data_o(rb_data_a),
    .busy_o(busy_a), .done_o(done_a), .sat_o(sat_a), .unsat_o(unsat_a),
    .timeout_o(timeout_a)
  );

  sat_engine_loader #(.WAIT_MAX(16), .READBACK(0)) u_dut_b (
    .clk(clk), .rst(rst), .go_i(go_b),
    .cur_bin_num_i(cur_bin), .load_lvl_i(load_lvl), .base_lvl_i(base_lvl),
    .var_states_i(var_states), .lvl_states_i(lvl_states),
    .cl_valid_i(cl_valid), .cl_ready_o(cl_ready_b), .cl_data_i(cl_data),
    .wr_carray_o(wr_carray_b), .rd_carray_o(rd_carray_b),
    .clause_o(clause_o_b), .clause_i(clause_i_b),
    .wr_var_states_o(wr_vs_b), .var_states_o(vs_o_b),
    .wr_lvl_states_o(wr_ls_b), .lvl_states_o(ls_o_b),
    .start_core_o(start_b), .cur_bin_num_o(cur_bin_o_b),
    .load_lvl_o(load_lvl_o_b), .base_lvl_o(base_lvl_o_b), .base_lvl_en_o(base_en_b),
    .done_core_i(done_core_b), .sat_i(sat_in), .unsat_i(unsat_in),
    .rb_valid_o(rb_valid_b), .rb_ready_i(rb_ready), .rb_data_o(rb_data_b),
    .busy_o(busy_b), .done_o(done_b), .sat_o(sat_b), .unsat_o(unsat_b),
    .timeout_o(timeout_b)
  );

  // Engine clause array model for instance A: synchronous write, combinational read.
  logic [NV*2-1:0] mem_a [NC];
  always @(posedge clk) begin
    for (int i = 0; i < NC; i++) if (wr_carray_a[i]) mem_a[i] <= clause_o_a;
  end
  always_comb begin
    clause_i_a = '0;
    for (int i = 0; i < NC; i++) if (rd_carray_a[i]) clause_i_a = mem_a[i];
  end

  int n_tests = 0, n_fail = 0;
  int rd_pulses_a = 0, start_pulses_a = 0, done_pulses_a = 0;
  int rd_pulses_b = 0, onehot_viol = 0;
  bit rbv_b_seen = 1'b0;

  always @(negedge clk) begin
    if (!$onehot0(wr_carray_a) || !$onehot0(rd_carray_a) ||
        !$onehot0(wr_carray_b) || !$onehot0(rd_carray_b)) onehot_viol++;
    if (rd_carray_a != '0) rd_pulses_a++;
    if (rd_carray_b != '0) rd_pulses_b++;
    if (start_a) start_pulses_a++;
    if (done_a) done_pulses_a++;
    if (rb_valid_b) rbv_b_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NV*2-1:0] cdat(input int job, input int i);
    return 16'(job * 4096 + i * 257 + 66);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input bit use_b);
    if (use_b) go_b = 1'b1; else go_a = 1'b1;
    step();
    go_a = 1'b0;
    go_b = 1'b0;
  endtask

  // Feeds NC clauses; optional one-cycle gap after each beat.
  task automatic feed(input int job, input bit gaps, input bit use_b);
    for (int i = 0; i < NC; i++) begin
      cl_valid = 1'b1;
      cl_data  = cdat(job, i);
      #1;
      chk("wr_row", use_b ? wr_carray_b : wr_carray_a, 256'(1) << i);
      chk("clause_o", use_b ? clause_o_b : clause_o_a, cdat(job, i));
      step();
      if (gaps && i < NC - 1) begin
        cl_valid = 1'b0;
        #1;
        chk("gap_wr", use_b ? wr_carray_b : wr_carray_a, 0);
        chk("gap_clause", use_b ? clause_o_b : clause_o_a, 0);
        chk("gap_ready", use_b ? cl_ready_b : cl_ready_a, 1);
        step();
      end
    end
    cl_valid = 1'b0;
  endtask

  task automatic readback(input int job, input int stall);
    logic [NV*2-1:0] held;
    rb_ready = 1'b0;
    for (int k = 0; k < NC; k++) begin
      chk("rd_row", rd_carray_a, 256'(1) << k);
      chk("rb_valid_req", rb_valid_a, 0);
      step();
      chk("rb_valid", rb_valid_a, 1);
      chk("rb_data", rb_data_a, cdat(job, k));
      held = rb_data_a;
      for (int s = 0; s < stall; s++) begin
        step();
        chk("rb_hold_valid", rb_valid_a, 1);
        chk("rb_hold_data", rb_data_a, held);
        chk("rb_hold_rd", rd_carray_a, 0);
      end
      rb_ready = 1'b1;
      step();
      rb_ready = 1'b0;
    end
  endtask

  initial begin
    int s0, r0, d0, cnt;

    #1;
    chk("rst_status_a", {busy_a, cl_ready_a, done_a, rb_valid_a, start_a, base_en_a,
                         sat_a, unsat_a, timeout_a}, 0);
    chk("rst_strobes_a", {wr_carray_a, rd_carray_a, wr_vs_a, wr_ls_a, clause_o_a}, 0);
    chk("rst_job_a", {cur_bin_o_a, load_lvl_o_a, base_lvl_o_a}, 0);
    chk("rst_status_b", {busy_b, cl_ready_b, done_b, timeout_b, rb_valid_b}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Job 1: fed with gaps, done after 20 cycles, sat, immediate readback.
    cur_bin    = 16'h0012;
    load_lvl   = 16'h0003;
    base_lvl   = 16'h0001;
    var_states = {8{19'h5A5A5}};
    lvl_states = {8{16'hC3C3}};
    s0 = start_pulses_a; r0 = rd_pulses_a; d0 = done_pulses_a;
    start_job(1'b0);
    chk("j1_busy", busy_a, 1);
    chk("j1_ready", cl_ready_a, 1);
    chk("j1_no_vs_yet", wr_vs_a, 0);
    feed(1, 1'b1, 1'b0);
    chk("j1_wr_vs", wr_vs_a, 8'hFF);
    chk("j1_vs_data", vs_o_a, {8{19'h5A5A5}});
    chk("j1_ready_off", cl_ready_a, 0);
    step();
    chk("j1_wr_ls", wr_ls_a, 8'hFF);
    chk("j1_ls_data", ls_o_a, {8{16'hC3C3}});
    chk("j1_vs_off", wr_vs_a, 0);
    step();
    chk("j1_start", {start_a, base_en_a}, 2'b11);
    chk("j1_job_regs", {cur_bin_o_a, load_lvl_o_a, base_lvl_o_a}, {16'h0012, 16'h0003, 16'h0001});
    step();
    chk("j1_start_off", {start_a, base_en_a}, 0);
    repeat (19) step();
    done_core_a = 1'b1; sat_in = 1'b1; unsat_in = 1'b0;
    step();
    done_core_a = 1'b0;
    chk("j1_sat_latched", {sat_a, unsat_a, timeout_a}, 3'b100);
    readback(1, 0);
    chk("j1_done", done_a, 1);
    step();
    chk("j1_idle", {busy_a, done_a}, 0);
    chk("j1_sat_hold", sat_a, 1);
    chk("j1_start_cnt", start_pulses_a - s0, 1);
    chk("j1_rd_cnt", rd_pulses_a - r0, 8);
    chk("j1_done_cnt", done_pulses_a - d0, 1);

    // Job 2: back-to-back feed, go while busy ignored, unsat, backpressured readback.
    cur_bin = 16'h0034;
    r0 = rd_pulses_a; d0 = done_pulses_a;
    start_job(1'b0);
    chk("j2_go_clears", {sat_a, unsat_a, timeout_a}, 0);
    feed(2, 1'b0, 1'b0);
    step();
    step();
    step();
    cur_bin = 16'hDEAD;
    go_a = 1'b1;
    step();
    go_a = 1'b0;
    chk("j2_go_ignored", cur_bin_o_a, 16'h0034);
    chk("j2_still_wait", {busy_a, cl_ready_a}, 2'b10);
    step();
    done_core_a = 1'b1; sat_in = 1'b0; unsat_in = 1'b1;
    step();
    done_core_a = 1'b0;
    readback(2, 5);
    chk("j2_done", done_a, 1);
    chk("j2_unsat", {sat_a, unsat_a}, 2'b01);
    step();
    chk("j2_rd_cnt", rd_pulses_a - r0, 8);
    chk("j2_done_cnt", done_pulses_a - d0, 1);

    // Instance B: timeout after WAIT_MAX=16 cycles.
    cur_bin = 16'h0056;
    start_job(1'b1);
    feed(3, 1'b0, 1'b1);
    step();
    step();
    chk("b_to_start", start_b, 1);
    cnt = 0;
    while (!done_b && cnt < 100) begin
      step();
      cnt++;
    end
    chk("b_to_latency", cnt, 16);
    chk("b_to_flags", {timeout_b, sat_b, unsat_b}, 3'b100);
    step();
    chk("b_to_idle", busy_b, 0);
    chk("b_to_hold", timeout_b, 1);

    // Instance B: READBACK=0, unsat verdict goes straight to FIN.
    start_job(1'b1);
    chk("b_go_clears_to", timeout_b, 0);
    feed(4, 1'b0, 1'b1);
    step();
    step();
    step();
    step();
    done_core_b = 1'b1; sat_in = 1'b0; unsat_in = 1'b1;
    step();
    done_core_b = 1'b0;
    chk("b_nr_done", done_b, 1);
    chk("b_nr_flags", {timeout_b, sat_b, unsat_b}, 3'b001);
    step();
    chk("b_nr_idle", {busy_b, done_b}, 0);
    chk("b_no_rb_valid", rbv_b_seen, 0);
    chk("b_no_rd", rd_pulses_b, 0);

    // Reset at clause row 3, then a clean job.
    start_job(1'b0);
    for (int i = 0; i < 3; i++) begin
      cl_valid = 1'b1;
      cl_data  = cdat(6, i);
      step();
    end
    cl_data = cdat(6, 3);
    #1;
    chk("rst_mid_row3", wr_carray_a, 8'h08);
    d0 = done_pulses_a;
    rst = 1'b1;
    #1;
    chk("rst_mid_status", {busy_a, cl_ready_a, done_a, rb_valid_a, start_a, sat_a,
                           unsat_a, timeout_a}, 0);
    chk("rst_mid_strobes", {wr_carray_a, rd_carray_a, wr_vs_a, wr_ls_a, clause_o_a}, 0);
    chk("rst_mid_job", {cur_bin_o_a, vs_o_a}, 0);
    cl_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    step();
    chk("rst_no_done", done_pulses_a - d0, 0);
    r0 = rd_pulses_a;
    start_job(1'b0);
    feed(5, 1'b0, 1'b0);
    step();
    step();
    step();
    step();
    done_core_a = 1'b1; sat_in = 1'b1; unsat_in = 1'b0;
    step();
    done_core_a = 1'b0;
    readback(5, 0);
    chk("clean_done", done_a, 1);
    chk("clean_sat", {sat_a, unsat_a, timeout_a}, 3'b100);
    step();
    chk("clean_rd_cnt", rd_pulses_a - r0, 8);
    chk("clean_done_cnt", done_pulses_a - d0, 1);
    chk("onehot_rows", onehot_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sat_engine_loader.md
SAT_ENGINE_LOADER -- requirements
Module: sat_engine_loader

Interface
REQ-001 Parameters SHALL be: NUM_CLAUSES 8 (clause rows per bin); NUM_VARS 8 (vars per bin); NUM_LVLS 8 (level slots); WIDTH_LVL 16 (level/bin-number width); WIDTH_VAR_STATES 19 (per-var state width); WIDTH_LVL_STATES 16 (per-level state width); WAIT_MAX 4096 (done-wait timeout in cycles); READBACK 1 (1 = read clause array back after solve).
REQ-002 Ports SHALL be: clk in 1, system clock; rst in 1, reset.
REQ-003 One clock; reset is asynchronous and active-high (ports clk, rst).
REQ-004 Job-side ports SHALL be: go_i in 1, job start pulse; cur_bin_num_i / load_lvl_i / base_lvl_i in WIDTH_LVL each, job control; var_states_i in WIDTH_VAR_STATES*NUM_VARS; lvl_states_i in WIDTH_LVL_STATES*NUM_LVLS.
REQ-005 Clause feed ports SHALL be: cl_valid_i in 1; cl_ready_o out 1; cl_data_i in NUM_VARS*2.
REQ-006 Engine-side ports SHALL be: wr_carray_o out NUM_CLAUSES; rd_carray_o out NUM_CLAUSES; clause_o out NUM_VARS*2; clause_i in NUM_VARS*2; wr_var_states_o out NUM_VARS; var_states_o out; wr_lvl_states_o out NUM_LVLS; lvl_states_o out; start_core_o out 1; cur_bin_num_o / load_lvl_o / base_lvl_o out WIDTH_LVL; base_lvl_en_o out 1; done_core_i in 1; sat_i in 1; unsat_i in 1.
REQ-007 Readback and status ports SHALL be: rb_valid_o out 1; rb_ready_i in 1; rb_data_o out NUM_VARS*2; busy_o out 1; done_o out 1 (one-cycle pulse); sat_o out 1; unsat_o out 1; timeout_o out 1.

Function
REQ-008 FSM states SHALL be IDLE, WR_CL, WR_VS, WR_LS, START, WAIT, RD_REQ, RD_OUT, FIN.
REQ-009 IDLE: go_i=1 SHALL register all job inputs and move to WR_CL; busy_o=1 in every state except IDLE; go_i while busy SHALL be ignored.
REQ-010 WR_CL: cl_ready_o=1; each cl_valid_i&cl_ready_o beat SHALL drive wr_carray_o one-hot bit row, with clause_o=cl_data_i in the same cycle, then row++; after row NUM_CLAUSES-1, go to WR_VS; without cl_valid_i, outputs zero and row holds.
REQ-011 WR_VS SHALL assert wr_var_states_o all-ones with var_states_o held for exactly one cycle, then go to WR_LS, which does the same with wr_lvl_states_o/lvl_states_o.
REQ-012 START SHALL assert start_core_o=1 and base_lvl_en_o=1 for one cycle, with cur_bin_num_o/load_lvl_o/base_lvl_o valid; then go to WAIT and clear the wait counter.
REQ-013 WAIT: done_core_i=1 SHALL latch sat_o<=sat_i and unsat_o<=unsat_i, then go to RD_REQ if READBACK=1, else FIN; the counter increments per cycle; counter reaching WAIT_MAX-1 without done SHALL set timeout_o=1 and go to FIN with no readback.
REQ-014 RD_REQ SHALL drive rd_carray_o one-hot bit row (row reset to 0 on WAIT exit) for one cycle; next cycle (RD_OUT) SHALL capture clause_i into rb_data_o and assert rb_valid_o.
REQ-015 RD_OUT SHALL hold rb_valid_o/rb_data_o stable until rb_ready_i=1; on handshake row++, then go to RD_REQ, or to FIN after row NUM_CLAUSES-1.
REQ-016 FIN SHALL pulse done_o for one cycle and return to IDLE; sat_o/unsat_o/timeout_o SHALL hold until the next accepted go_i, which clears them.
REQ-017 All engine strobes (wr_*, rd_*, start_core_o, base_lvl_en_o) SHALL be zero outside their states; at most one row bit is ever set.
REQ-018 Row counter width SHALL be $clog2(NUM_CLAUSES) (min 1); the wait counter SHALL be $clog2(WAIT_MAX)+1 bits and SHALL not wrap.

Reset
REQ-019 rst=1 SHALL asynchronously force IDLE and zero all outputs, counters and job registers; cl_ready_o=0, rb_valid_o=0.
REQ-020 Reset mid-job SHALL abandon the job with no done_o pulse; a partial clause load is discarded.

Structure
REQ-021 The state enum and default width constants SHALL live in shared package sat_pkg.
REQ-022 The one-hot row decoder SHALL be a sub-module onehot_dec (binary in, NUM_CLAUSES one-hot out, enable).

Verification
REQ-023 Full job: 8 clauses, done_core_i after 20 cycles with sat_i=1 -> 8 wr_carray_o beats 01..80, one start pulse, 8 readback beats, done_o, sat_o=1.
REQ-024 Feed gaps: cl_valid_i toggled 1/0 -> row advances only on valid beats; wr_carray_o=0 in gap cycles.
REQ-025 Backpressure: rb_ready_i low 5 cycles per beat -> rb_data_o stable, no extra rd_carray_o pulses.
REQ-026 Timeout: WAIT_MAX=16, done_core_i never asserted -> timeout_o=1 and done_o exactly 16 cycles after start, no rd_carray_o.
REQ-027 READBACK=0 with unsat_i=1 -> FIN right after done_core_i, unsat_o=1, rb_valid_o never set.
REQ-028 rst pulse during WR_CL row 3 -> IDLE immediately, all outputs 0, no done_o; a subsequent go_i runs a clean job.
